// File: rtl/risc_prog_loader_pkg.sv
// risc_loader_pkg: shared constants and the FSM state type for the
// RISC_SPM boot-time program loader.
//   WORD_SIZE : processor word size; the loader's data and address width.
//   state_t   : loader FSM states. CHK is reachable only when the loader is
//               built with LOADER_CHKSUM_EN defined.
package risc_loader_pkg;
   localparam int WORD_SIZE = 8;

   typedef enum logic [2:0] {
      IDLE, LEN, DATA, WR, CHK, DONE, ERR
   } state_t;
endpackage

// File: rtl/risc_prog_loader_if.sv
// risc_prog_loader_if: the byte-stream handshake plus the memory write port
// driven by the loader.
//   in_valid/in_data/in_ready : valid/ready byte stream into the loader.
//   mem_addr/mem_data/mem_write: sequential write port into program memory.
// Modports:
//   slave  : loader side (consumes the stream, drives the memory port).
//   master : stream source / memory side.
interface risc_prog_loader_if #(parameter int W = 8);
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic [W-1:0] mem_addr;
   logic [W-1:0] mem_data;
   logic         mem_write;

   modport slave  (input  in_valid, in_data,
                   output in_ready, mem_addr, mem_data, mem_write);
   modport master (output in_valid, in_data,
                   input  in_ready, mem_addr, mem_data, mem_write);
endinterface

// File: rtl/risc_prog_loader.sv
// risc_prog_loader: boot loader for RISC_SPM. It receives a length byte N,
// then N data bytes, and writes them to program memory from BASE_ADDR
// upward. The processor is held in reset (cpu_hold=1) until the image is
// complete.
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-low reset.
//   start     : one-cycle pulse; starts a load from IDLE, DONE or ERR.
//   bus       : stream handshake plus memory write port (slave modport).
//   cpu_hold  : high keeps the processor in reset.
//   busy      : high while a load is in progress.
//   done      : high when the image is loaded and the CPU is running.
//   error     : high after an aborted load.
// Build option: define LOADER_CHKSUM_EN to require a trailing checksum byte.
// The 8-bit sum of N, all data bytes and the checksum must be zero.
// All outputs are registered.
module risc_prog_loader #(
   parameter int                   WORD_SIZE = risc_loader_pkg::WORD_SIZE,
   parameter logic [WORD_SIZE-1:0] BASE_ADDR = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   risc_prog_loader_if.slave        bus,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);
   import risc_loader_pkg::*;

   state_t               state, nxt;
   logic [WORD_SIZE-1:0] cnt;
   logic                 acc;
   logic                 rdy_d, wr_d, hold_d, busy_d, done_d, err_d;

`ifdef LOADER_CHKSUM_EN
   logic [WORD_SIZE-1:0] sum;
   localparam state_t AFTER_LAST = CHK;
`else
   localparam state_t AFTER_LAST = DONE;
`endif

   assign acc = bus.in_valid & bus.in_ready;

   // State register together with the registered control outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b0;
         bus.mem_write <= 1'b0;
         cpu_hold      <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         state         <= nxt;
         bus.in_ready  <= rdy_d;
         bus.mem_write <= wr_d;
         cpu_hold      <= hold_d;
         busy          <= busy_d;
         done          <= done_d;
         error         <= err_d;
      end
   end

   // Next-state logic; start is only honoured in the idle-like states
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, DONE, ERR: if (start) nxt = LEN;
         LEN:  if (acc) nxt = (bus.in_data == '0) ? ERR : DATA;
         DATA: if (acc) nxt = WR;
         // cnt still holds the pre-decrement value here
         WR:   nxt = (cnt == WORD_SIZE'(1)) ? AFTER_LAST : DATA;
`ifdef LOADER_CHKSUM_EN
         CHK:  if (acc) nxt = (WORD_SIZE'(sum + bus.in_data) == '0) ? DONE : ERR;
`endif
         default: nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that they are registered
   // yet line up with the state they describe.
   always_comb begin
      rdy_d  = (nxt == LEN) || (nxt == DATA) || (nxt == CHK);
      wr_d   = (nxt == WR);
      hold_d = (nxt != DONE);
      busy_d = (nxt == LEN) || (nxt == DATA) || (nxt == WR) || (nxt == CHK);
      done_d = (nxt == DONE);
      err_d  = (nxt == ERR);
   end

   // Datapath: byte counter, address, write data and optional running sum
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         bus.mem_addr <= BASE_ADDR;
         bus.mem_data <= '0;
`ifdef LOADER_CHKSUM_EN
         sum          <= '0;
`endif
      end else begin
         unique case (state)
            LEN: if (acc) begin
               cnt          <= bus.in_data;
               bus.mem_addr <= BASE_ADDR;
`ifdef LOADER_CHKSUM_EN
               sum          <= bus.in_data;  // sum restarts with N
`endif
            end
            DATA: if (acc) begin
               bus.mem_data <= bus.in_data;
`ifdef LOADER_CHKSUM_EN
               sum          <= sum + bus.in_data;
`endif
            end
            WR: begin
               bus.mem_addr <= bus.mem_addr + WORD_SIZE'(1);  // wraps naturally
               cnt          <= cnt - WORD_SIZE'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_risc_prog_loader.sv
// tb_risc_prog_loader: directed bench for risc_prog_loader. Two instances
// share one stimulus stream: u0 with BASE_ADDR=0x00, and u1 with
// BASE_ADDR=0xFE for the address-wrap case. Memory writes are logged at
// the falling edge. With LOADER_CHKSUM_EN, each complete image is
// followed by its checksum byte.
module tb_risc_prog_loader;
   import risc_loader_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       hold0, busy0, done0, err0, hold1, busy1, done1, err1;
   int         checks = 0, failures = 0, cyc = 0;
   logic [7:0] run_sum = 8'h00;
   logic [15:0] wq0[$], wq1[$];
   int          wcyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   risc_prog_loader_if #(.W(8)) bus0();
   risc_prog_loader_if #(.W(8)) bus1();
   assign bus0.in_valid = in_valid;
   assign bus0.in_data  = in_data;
   assign bus1.in_valid = in_valid;
   assign bus1.in_data  = in_data;

   risc_prog_loader #(.WORD_SIZE(8), .BASE_ADDR(8'h00)) u0 (
      .clk(clk), .rst(rst), .start(start), .bus(bus0),
      .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0));
   risc_prog_loader #(.WORD_SIZE(8), .BASE_ADDR(8'hFE)) u1 (
      .clk(clk), .rst(rst), .start(start), .bus(bus1),
      .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1));

   always @(negedge clk) begin
      if (bus0.mem_write) begin
         wq0.push_back({bus0.mem_addr, bus0.mem_data});
         wcyc.push_back(cyc);
      end
      if (bus1.mem_write) wq1.push_back({bus1.mem_addr, bus1.mem_data});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      run_sum = 8'h00;
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!bus0.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("send_rdy", {31'd0, bus0.in_ready}, 32'd1);
      else @(posedge clk);
      run_sum = run_sum + b;
   endtask

   // Closes an image: the checksum byte when enabled, then idle the stream
   task automatic finish_img();
`ifdef LOADER_CHKSUM_EN
      send(8'h00 - run_sum);
`endif
      @(negedge clk) in_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_log();
      wq0.delete(); wq1.delete(); wcyc.delete();
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, bus0.in_ready}, 32'd0);
      chk("rst_wr",    {31'd0, bus0.mem_write}, 32'd0);
      chk("rst_addr0", {24'd0, bus0.mem_addr}, 32'h00);
      chk("rst_addr1", {24'd0, bus1.mem_addr}, 32'hFE);
      chk("rst_data",  {24'd0, bus0.mem_data}, 32'h00);
      chk("rst_flags", {28'd0, hold0, busy0, done0, err0}, 32'b1000);
      rst = 1'b1;

      // Basic load, in_valid held high
      pulse_start();
      chk("len_ready", {30'd0, bus0.in_ready, busy0}, 32'b11);
      send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3);
      finish_img();
      chk("bas_nwr", wq0.size(), 3);
      if (wq0.size() == 3) begin
         chk("bas_w0", {16'd0, wq0[0]}, 32'h00A1);
         chk("bas_w1", {16'd0, wq0[1]}, 32'h01B2);
         chk("bas_w2", {16'd0, wq0[2]}, 32'h02C3);
         chk("bas_gap", wcyc[1] - wcyc[0], 2);
      end
      chk("wrap_n", wq1.size(), 3);
      if (wq1.size() == 3) begin
         chk("wrap_w0", {16'd0, wq1[0]}, 32'hFEA1);
         chk("wrap_w1", {16'd0, wq1[1]}, 32'hFFB2);
         chk("wrap_w2", {16'd0, wq1[2]}, 32'h00C3);
      end
      chk("bas_done", {28'd0, hold0, busy0, done0, err0}, 32'b0010);

      // Backpressure, plus a start pulse while busy that must be ignored
      clear_log();
      pulse_start();
      chk("restart_hold", {30'd0, hold0, done0}, 32'b10);
      send(8'h03); send(8'hA1);
      @(negedge clk) in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      chk("bp_nwr", wq0.size(), 1);
      chk("bp_busy", {31'd0, busy0}, 32'd1);
      send(8'hB2); send(8'hC3);
      finish_img();
      chk("bp_n", wq0.size(), 3);
      if (wq0.size() == 3) begin
         chk("bp_w1", {16'd0, wq0[1]}, 32'h01B2);
         chk("bp_w2", {16'd0, wq0[2]}, 32'h02C3);
      end
      chk("bp_done", {31'd0, done0}, 32'd1);

      // Zero length, then recovery
      clear_log();
      pulse_start();
      send(8'h00);
      @(negedge clk) in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("zl_flags", {28'd0, hold0, busy0, done0, err0}, 32'b1001);
      chk("zl_ready", {31'd0, bus0.in_ready}, 32'd0);
      chk("zl_nwr", wq0.size(), 0);
      pulse_start();
      chk("zl_clr", {31'd0, err0}, 32'd0);
      send(8'h01); send(8'h5A);
      finish_img();
      chk("zl_rec", {28'd0, hold0, busy0, done0, err0}, 32'b0010);
      chk("zl_w", (wq0.size() == 1) ? {16'd0, wq0[0]} : 32'hDEAD, 32'h005A);

      // Asynchronous reset mid-load, after 2 of 4 data bytes
      clear_log();
      pulse_start();
      send(8'h04); send(8'h11); send(8'h22);
      @(negedge clk) in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mr_flags", {28'd0, hold0, busy0, done0, err0}, 32'b1000);
      chk("mr_bus", {22'd0, bus0.in_ready, bus0.mem_write, bus0.mem_addr},
          32'h000);
      chk("mr_data", {24'd0, bus0.mem_data}, 32'h00);
      chk("mr_state", 32'(u0.state), 32'(IDLE));
      chk("mr_nwr", wq0.size(), 2);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mr_idle", {29'd0, hold0, busy0, bus0.in_ready}, 32'b100);

`ifdef LOADER_CHKSUM_EN
      // Good checksum
      clear_log();
      pulse_start();
      send(8'h02); send(8'h10); send(8'h20); send(8'hCE);
      @(negedge clk) in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("cs_ok", {28'd0, hold0, busy0, done0, err0}, 32'b0010);
      chk("cs_nwr", wq0.size(), 2);
      // Bad checksum
      pulse_start();
      send(8'h02); send(8'h10); send(8'h20); send(8'hCF);
      @(negedge clk) in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("cs_bad", {28'd0, hold0, busy0, done0, err0}, 32'b1001);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/risc_prog_loader.md
Name: risc_prog_loader

Overview:
- Boot-time program loader upstream of the RISC_SPM processor and its memory unit.
- Accepts a byte stream over a valid/ready handshake and writes it sequentially into the 8-bit program memory through the memory write port.
- Holds the processor in reset until the image is fully written, then releases it.
- Sits beside the processor on the memory's address/data_in/write inputs; the top level muxes those inputs on cpu_hold.

Parameters:
- WORD_SIZE, 8, data and address width; equals the processor word size.
- BASE_ADDR, 8'h00, first memory address written.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  stream byte valid.
- in_data  in  WORD_SIZE  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_addr  out  WORD_SIZE  memory address.
- mem_data  out  WORD_SIZE  memory write data.
- mem_write  out  1  memory write strobe, one cycle per byte.
- cpu_hold  out  1  high holds the processor in reset.
- busy  out  1  load in progress.
- done  out  1  image loaded, processor running.
- error  out  1  load aborted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=0, mem_write=0, mem_addr=BASE_ADDR, mem_data=0, cpu_hold=1, busy=0, done=0, error=0; byte counter=0.
- A byte is accepted only on a clock edge where in_valid=1 and in_ready=1.
- IDLE: cpu_hold=1. start moves to LEN.
- LEN: in_ready=1, busy=1.
  - The accepted byte is the length N.
  - N=0 moves to ERR.
  - Otherwise counter=N, mem_addr=BASE_ADDR, and the state moves to DATA.
- DATA: in_ready=1.
  - The accepted byte is registered into mem_data.
  - The state moves to WR.
- WR: in_ready=0, mem_write=1 for exactly this cycle, with mem_addr and mem_data stable.
  - Next cycle: mem_addr increments modulo 2^WORD_SIZE (0xFF wraps to 0x00) and the counter decrements.
  - If the counter reaches 0, move to DONE (or CHK when the optional feature is enabled); otherwise move to DATA.
- Throughput: at most 1 byte per 2 cycles. Latency: write strobe fires 1 cycle after acceptance.
- DONE: cpu_hold=0, done=1, busy=0, in_ready=0. start reasserts cpu_hold the next cycle and moves to LEN, clearing done.
- ERR: cpu_hold=1, error=1, in_ready=0. start clears error and moves to LEN.
- start while busy (LEN/DATA/WR/CHK) is ignored.
- in_valid with in_ready=0 is not consumed; the source must hold the byte.
- Reset mid-load aborts immediately and returns to IDLE. Memory contents already written are left unchanged; cpu_hold stays 1.
- All outputs are registered.

Optional Feature:
- Macro: LOADER_CHKSUM_EN.
- Enabled:
  - After the N data bytes, state CHK accepts one checksum byte with in_ready=1 and no memory write.
  - The 8-bit sum of N, all data bytes and the checksum must equal 0x00. Pass moves to DONE; mismatch moves to ERR.
  - The running sum register resets to 0 and restarts on each LEN.
- Disabled: no CHK state and no sum register; the last WR moves directly to DONE.

Decomposition:
- Package risc_loader_pkg:
  - WORD_SIZE constant.
  - State enum: IDLE, LEN, DATA, WR, CHK, DONE, ERR.
- No sub-module; the counter, address register and FSM are small enough to stay inline.

Test Plan:
- Basic load: reset, start, stream 0x03, 0xA1, 0xB2, 0xC3 with in_valid held high. Expect mem_write at addr 0x00/0x01/0x02 with data A1/B2/C3, one cycle each with a gap cycle between. Then done=1 and cpu_hold=0.
- Backpressure: drop in_valid for 5 cycles mid-stream. Expect no spurious mem_write, and the same final memory image as the basic load.
- Zero length: start, send 0x00. Expect error=1, cpu_hold=1, no mem_write. A following start with a valid stream recovers to done=1.
- Address wrap: BASE_ADDR=0xFE, N=3. Expect writes at 0xFE, 0xFF, 0x00.
- Reset mid-load: assert rst=0 after 2 of 4 data bytes. Expect all outputs at reset values asynchronously, cpu_hold=1, and state IDLE.
- LOADER_CHKSUM_EN: stream 0x02, 0x10, 0x20, then checksum 0xCE. Expect done=1. With checksum 0xCF, expect error=1 and cpu_hold=1.
